pwm_fade_ctrl: RTL and testbench

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

---
 rtl/pwm_fade_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle fade sequencer: steps a 4-bit PWM duty toward a latched target, one LSB per step tick.
// Define PWM_FADE_BREATHE_EN to enable breathe mode (RAMP -> HOLD -> FALL -> RAMP looping).
module pwm_fade_ctrl #(
    parameter int unsigned PWM_FREQ     = 1_000,
    parameter int unsigned CLK_FREQ     = 200_000_000,
    parameter int unsigned STEP_PERIODS = 8,
    parameter int unsigned HOLD_STEPS   = 16
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] target_duty,
    output logic [3:0] duty_cycle,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_THRESH = CLK_FREQ / PWM_FREQ;
    localparam int unsigned CntW  = (CNT_THRESH > 1) ? $clog2(CNT_THRESH) : 1;
    localparam int unsigned StepW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [CntW-1:0]  FrameLast = CntW'(CNT_THRESH - 1);
    localparam logic [StepW-1:0] StepLast  = StepW'(STEP_PERIODS - 1);

    if (STEP_PERIODS == 0 || HOLD_STEPS == 0 || CNT_THRESH == 0) begin : g_param_check
        $error("pwm_fade_ctrl: STEP_PERIODS, HOLD_STEPS and CLK_FREQ/PWM_FREQ must be >= 1");
    end

    typedef enum logic [1:0] {StIdle, StRamp, StHold, StFall} state_e;

    state_e           state_q, state_d;
    logic [3:0]       duty_q, duty_d;
    logic [3:0]       target_q, target_d;
    logic [CntW-1:0]  frame_cnt_q, frame_cnt_d;
    logic [StepW-1:0] step_cnt_q, step_cnt_d;
    logic             done_q, done_d;
    logic             frame_tick, step_tick;

`ifdef PWM_FADE_BREATHE_EN
    localparam int unsigned HoldW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_STEPS - 1);
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
`endif

    assign frame_tick = (frame_cnt_q == FrameLast);
    assign step_tick  = frame_tick && (step_cnt_q == StepLast);

    always_comb begin
        state_d     = state_q;
        duty_d      = duty_q;
        target_d    = target_q;
        frame_cnt_d = frame_cnt_q;
        step_cnt_d  = step_cnt_q;
        done_d      = 1'b0;
`ifdef PWM_FADE_BREATHE_EN
        hold_cnt_d  = hold_cnt_q;
`endif

        // Frame/step counters free-run while a fade is active and freeze in idle.
        if (state_q != StIdle) begin
            if (frame_tick) begin
                frame_cnt_d = '0;
                step_cnt_d  = step_tick ? '0 : step_cnt_q + StepW'(1);
            end else begin
                frame_cnt_d = frame_cnt_q + CntW'(1);
            end
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    target_d    = target_duty;
                    frame_cnt_d = '0;
                    step_cnt_d  = '0;
                    state_d     = StRamp;
                end
            end
            StRamp: begin
                if (duty_q == target_q) begin
`ifdef PWM_FADE_BREATHE_EN
                    if (target_q == 4'd0) begin
                        done_d = step_tick;
                    end else begin
                        hold_cnt_d = '0;
                        state_d    = StHold;
                    end
`else
                    done_d  = 1'b1;
                    state_d = StIdle;
`endif
                end else if (step_tick) begin
                    duty_d = (duty_q < target_q) ? duty_q + 4'd1 : duty_q - 4'd1;
                end
            end
`ifdef PWM_FADE_BREATHE_EN
            StHold: begin
                // The final hold tick also takes the first fall step, so the dwell at
                // target is exactly HOLD_STEPS step periods.
                if (step_tick) begin
                    if (hold_cnt_q == HoldLast) begin
                        duty_d  = duty_q - 4'd1;
                        state_d = StFall;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HoldW'(1);
                    end
                end
            end
            StFall: begin
                if (duty_q == 4'd0) begin
                    done_d  = 1'b1;
                    state_d = StRamp;
                end else if (step_tick) begin
                    duty_d = duty_q - 4'd1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // Stop overrides everything, including a simultaneous start.
        if (stop) begin
            state_d     = StIdle;
            duty_d      = 4'd0;
            frame_cnt_d = '0;
            step_cnt_d  = '0;
            done_d      = 1'b0;
`ifdef PWM_FADE_BREATHE_EN
            hold_cnt_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= StIdle;
            duty_q      <= 4'd0;
            target_q    <= 4'd0;
            frame_cnt_q <= '0;
            step_cnt_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            target_q    <= target_d;
            frame_cnt_q <= frame_cnt_d;
            step_cnt_q  <= step_cnt_d;
            done_q      <= done_d;
        end
    end

`ifdef PWM_FADE_BREATHE_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`endif

    assign duty_cycle = duty_q;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: 20 clocks per duty step, HOLD_STEPS = 2.
module tb_pwm_fade_ctrl;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       start;
    logic       stop;
    logic [3:0] target_duty;
    logic [3:0] duty_cycle;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pwm_fade_ctrl #(
        .PWM_FREQ    (100),
        .CLK_FREQ    (1000),
        .STEP_PERIODS(2),
        .HOLD_STEPS  (2)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .start      (start),
        .stop       (stop),
        .target_duty(target_duty),
        .duty_cycle (duty_cycle),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic outs(input string tag, input logic [3:0] d, input logic b, input logic dn);
        check({tag, ".duty"}, duty_cycle, d);
        check({tag, ".busy"}, {3'b0, busy}, {3'b0, b});
        check({tag, ".done"}, {3'b0, done}, {3'b0, dn});
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start is sampled on the next edge (edge 0 of the fade).
    task automatic accept(input logic [3:0] tgt);
        start       = 1'b1;
        target_duty = tgt;
        cyc(1);
        start       = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    initial begin
        arst_n      = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        target_duty = 4'd0;
        #12;
        outs("reset", 4'd0, 1'b0, 1'b0);
        arst_n = 1'b1;
        cyc(2);
        outs("post_reset_idle", 4'd0, 1'b0, 1'b0);

`ifdef PWM_FADE_BREATHE_EN
        accept(4'd2);
        cyc(19); check("br_e19", duty_cycle, 4'd0);
        cyc(1);  check("br_e20", duty_cycle, 4'd1);
        cyc(20); check("br_e40", duty_cycle, 4'd2);
        cyc(1);  outs("br_hold_e41", 4'd2, 1'b1, 1'b0);
        cyc(38); check("br_hold_e79", duty_cycle, 4'd2);
        cyc(1);  outs("br_fall_e80", 4'd1, 1'b1, 1'b0);
        cyc(20); outs("br_fall_e100", 4'd0, 1'b1, 1'b0);
        cyc(1);  outs("br_done_e101", 4'd0, 1'b1, 1'b1);
        cyc(1);  outs("br_e102", 4'd0, 1'b1, 1'b0);
        cyc(18); check("br_rep_e120", duty_cycle, 4'd1);
        cyc(20); check("br_rep_e140", duty_cycle, 4'd2);
        cyc(15);
        #3 arst_n = 1'b0;
        #1 outs("br_reset_mid_hold", 4'd0, 1'b0, 1'b0);
        #2 arst_n = 1'b1;
        cyc(40);
        outs("br_after_reset", 4'd0, 1'b0, 1'b0);
`else
        // Fade up 0 -> 5.
        accept(4'd5);
        outs("up_e0", 4'd0, 1'b1, 1'b0);
        cyc(19); check("up_e19", duty_cycle, 4'd0);
        cyc(1);  check("up_e20", duty_cycle, 4'd1);
        cyc(79); check("up_e99", duty_cycle, 4'd4);
        cyc(1);  outs("up_e100", 4'd5, 1'b1, 1'b0);
        cyc(1);  outs("up_done", 4'd5, 1'b0, 1'b1);
        cyc(1);  outs("up_after", 4'd5, 1'b0, 1'b0);

        // Fade down 5 -> 2.
        accept(4'd2);
        cyc(20); check("dn_e20", duty_cycle, 4'd4);
        cyc(20); check("dn_e40", duty_cycle, 4'd3);
        cyc(20); outs("dn_e60", 4'd2, 1'b1, 1'b0);
        cyc(1);  outs("dn_done", 4'd2, 1'b0, 1'b1);
        cyc(20); outs("dn_hold", 4'd2, 1'b0, 1'b0);

        // Stop from idle clears duty; then abort a fade toward 15 at edge 50.
        pulse_stop();
        outs("stop_idle", 4'd0, 1'b0, 1'b0);
        accept(4'd15);
        cyc(40); check("ab_e40", duty_cycle, 4'd2);
        cyc(9);
        pulse_stop();
        outs("ab_stop_e50", 4'd0, 1'b0, 1'b0);
        cyc(1);  outs("ab_e51", 4'd0, 1'b0, 1'b0);
        cyc(30); outs("ab_quiet", 4'd0, 1'b0, 1'b0);

        // Reach duty 3, then start+stop together: stop wins.
        accept(4'd3);
        cyc(60); check("ss_e60", duty_cycle, 4'd3);
        cyc(1);  outs("ss_done", 4'd3, 1'b0, 1'b1);
        start = 1'b1; stop = 1'b1; target_duty = 4'd9;
        cyc(1);
        start = 1'b0; stop = 1'b0;
        outs("ss_both", 4'd0, 1'b0, 1'b0);
        cyc(25); outs("ss_nofade", 4'd0, 1'b0, 1'b0);

        // Start while busy is ignored; target changes after acceptance are ignored.
        accept(4'd3);
        cyc(10);
        start = 1'b1; target_duty = 4'd7;
        cyc(1);
        start = 1'b0;
        cyc(9);  check("bz_e20", duty_cycle, 4'd1);
        cyc(40); outs("bz_e60", 4'd3, 1'b1, 1'b0);
        cyc(1);  outs("bz_done", 4'd3, 1'b0, 1'b1);
        cyc(20); outs("bz_stay", 4'd3, 1'b0, 1'b0);

        // Target equal to current duty: done one cycle after acceptance.
        accept(4'd3);
        outs("eq_e0", 4'd3, 1'b1, 1'b0);
        cyc(1);  outs("eq_done", 4'd3, 1'b0, 1'b1);

        // Reset asserted mid-fade aborts immediately.
        accept(4'd9);
        cyc(30);
        check("rst_e30", duty_cycle, 4'd4);
        #3 arst_n = 1'b0;
        #1 outs("rst_mid", 4'd0, 1'b0, 1'b0);
        #2 arst_n = 1'b1;
        cyc(30);
        outs("rst_after", 4'd0, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
